// File: rtl/issue_pair.sv
// Dual-issue pairing stage between fetch and decode.
// Steers each fetched instruction to a decode slot; slot 1 is the memory pipe.
module issue_pair #(
    parameter logic [31:0] NOP = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrF_0,
    input  logic [31:0] instrF_1,
    input  logic [31:0] PCF,
    input  logic        validF,
    input  logic        stallD,
    input  logic        flushD,
    output logic [31:0] instrD_0,
    output logic [31:0] instrD_1,
    output logic [31:0] PCD_0,
    output logic [31:0] PCD_1,
    output logic        validD_0,
    output logic        validD_1,
    output logic        swappedD,
    output logic        stallF
);

    typedef enum logic {PAIR, SECOND} state_t;

    state_t      state;
    logic [31:0] cap_instr;
    logic [31:0] cap_pc;

    function automatic logic is_mem(input logic [31:0] x);
        return (x[6:0] == 7'b0000011) || (x[6:0] == 7'b0100011);
    endfunction

    function automatic logic is_ctrl(input logic [31:0] x);
        return (x[6:0] == 7'b1100011) || (x[6:0] == 7'b1101111) ||
               (x[6:0] == 7'b1100111);
    endfunction

    // Stores and branches have no rd; rd=x0 writes nothing
    function automatic logic is_wr(input logic [31:0] x);
        return (x[6:0] != 7'b0100011) && (x[6:0] != 7'b1100011) &&
               (x[11:7] != 5'd0);
    endfunction

    logic        mem0, mem1, ctrl0, ctrl1;
    logic        dep10, dep01;
    logic        straight, swap, split;
    logic [31:0] pc_young;

    // Pair classification and issue decision on the fetch inputs
    always_comb begin
        mem0  = is_mem(instrF_0);
        mem1  = is_mem(instrF_1);
        ctrl0 = is_ctrl(instrF_0);
        ctrl1 = is_ctrl(instrF_1);
        dep10 = is_wr(instrF_0) &&
                ((instrF_0[11:7] == instrF_1[19:15]) ||
                 (instrF_0[11:7] == instrF_1[24:20]));
        dep01 = is_wr(instrF_1) &&
                ((instrF_1[11:7] == instrF_0[19:15]) ||
                 (instrF_1[11:7] == instrF_0[24:20]) ||
                 (instrF_1[11:7] == instrF_0[11:7]));
        straight = !mem0 && !dep10 && !ctrl0;
        swap     = mem0 && !mem1 && !dep10 && !dep01 && !ctrl0 && !ctrl1;
        split    = !straight && !swap;
        pc_young = PCF + 32'd4;
    end

    // Fetch holds its pair while the older half of a split issues
    assign stallF = !rst && (state == PAIR) && validF && split && !flushD;

    // Decode slot registers, split capture and pairing state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instrD_0  <= NOP;
            instrD_1  <= NOP;
            PCD_0     <= '0;
            PCD_1     <= '0;
            validD_0  <= 1'b0;
            validD_1  <= 1'b0;
            swappedD  <= 1'b0;
            cap_instr <= NOP;
            cap_pc    <= '0;
            state     <= PAIR;
        end else if (flushD) begin
            instrD_0 <= NOP;
            instrD_1 <= NOP;
            PCD_0    <= '0;
            PCD_1    <= '0;
            validD_0 <= 1'b0;
            validD_1 <= 1'b0;
            swappedD <= 1'b0;
            state    <= PAIR;
        end else if (!stallD) begin
            swappedD <= 1'b0;
            unique case (state)
                PAIR: begin
                    if (!validF) begin
                        instrD_0 <= NOP;
                        instrD_1 <= NOP;
                        PCD_0    <= '0;
                        PCD_1    <= '0;
                        validD_0 <= 1'b0;
                        validD_1 <= 1'b0;
                    end else if (straight) begin
                        instrD_0 <= instrF_0;
                        instrD_1 <= instrF_1;
                        PCD_0    <= PCF;
                        PCD_1    <= pc_young;
                        validD_0 <= 1'b1;
                        validD_1 <= 1'b1;
                    end else if (swap) begin
                        instrD_0 <= instrF_1;
                        instrD_1 <= instrF_0;
                        PCD_0    <= pc_young;
                        PCD_1    <= PCF;
                        validD_0 <= 1'b1;
                        validD_1 <= 1'b1;
                        swappedD <= 1'b1;
                    end else begin
                        instrD_0  <= mem0 ? NOP : instrF_0;
                        instrD_1  <= mem0 ? instrF_0 : NOP;
                        PCD_0     <= mem0 ? '0 : PCF;
                        PCD_1     <= mem0 ? PCF : '0;
                        validD_0  <= !mem0;
                        validD_1  <= mem0;
                        cap_instr <= instrF_1;
                        cap_pc    <= pc_young;
                        state     <= SECOND;
                    end
                end
                SECOND: begin
                    instrD_0 <= is_mem(cap_instr) ? NOP : cap_instr;
                    instrD_1 <= is_mem(cap_instr) ? cap_instr : NOP;
                    PCD_0    <= is_mem(cap_instr) ? '0 : cap_pc;
                    PCD_1    <= is_mem(cap_instr) ? cap_pc : '0;
                    validD_0 <= !is_mem(cap_instr);
                    validD_1 <= is_mem(cap_instr);
                    state    <= PAIR;
                end
                default: state <= PAIR;
            endcase
        end
    end

endmodule
